// File: rtl/svm_window_scheduler.sv
// ---------------------------------------------------------------------------
// svm_window_scheduler
//
// Purpose: walks every sliding window of one HOG block-feature frame in raster
// order (wx fastest, then wy, stride one block). It answers each SVM word
// request with the next block word of the current window (bx fastest, then by),
// fetched from the frame feature buffer. It then collects one classification
// per window and reports it together with the window id.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           frame features complete in buffer (ignored while busy)
//   busy, done      frame in progress / one-cycle end-of-frame pulse
//   rd_en, rd_addr  buffer read strobe and address
//   rd_data         buffer word, valid one cycle after rd_en
//   svm_request     SVM asks for the next block word
//   svm_ready       one-cycle pulse, svm_data valid
//   svm_data        block word to SVM (holds between pulses)
//   svm_o_valid     SVM window result valid
//   svm_is_person   SVM decision
//   svm_result      SVM score
//   det_valid       one-cycle pulse per reported window
//   det_sw_id       window id of the reported result
//   det_is_person   registered decision
//   det_score       registered score
//   person_cnt      persons found this frame (saturating)
//
// Optional build macro SCHED_TIMEOUT_EN adds parameter TIMEOUT and the
// sticky output err_timeout. A window whose result does not arrive within
// TIMEOUT cycles is reported as "no person, score 0", and the frame goes on.
// ---------------------------------------------------------------------------
module svm_window_scheduler #(
    parameter int DATA_W  = 768,
    parameter int SW_W    = 11,
    parameter int FRM_BX  = 39,
    parameter int FRM_BY  = 29,
    parameter int WIN_BX  = 7,
    parameter int WIN_BY  = 15,
    parameter int ADDR_W  = 11,
    parameter int FEA_W   = 32
`ifdef SCHED_TIMEOUT_EN
    , parameter int TIMEOUT = 1023
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              svm_request,
    output logic              svm_ready,
    output logic [DATA_W-1:0] svm_data,
    input  logic              svm_o_valid,
    input  logic              svm_is_person,
    input  logic [FEA_W-1:0]  svm_result,
    output logic              det_valid,
    output logic [SW_W-1:0]   det_sw_id,
    output logic              det_is_person,
    output logic [FEA_W-1:0]  det_score,
    output logic [SW_W-1:0]   person_cnt
`ifdef SCHED_TIMEOUT_EN
    , output logic            err_timeout
`endif
);
    localparam int NWX  = FRM_BX - WIN_BX + 1;
    localparam int NWY  = FRM_BY - WIN_BY + 1;
    localparam int BX_W = $clog2(WIN_BX + 1);
    localparam int BY_W = $clog2(WIN_BY + 1);
    localparam int WX_W = $clog2(NWX + 1);
    localparam int WY_W = $clog2(NWY + 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_WAIT_REQ = 3'd1;
    localparam logic [2:0] S_READ     = 3'd2;
    localparam logic [2:0] S_LOAD     = 3'd3;
    localparam logic [2:0] S_PRESENT  = 3'd4;
    localparam logic [2:0] S_WAIT_RES = 3'd5;
    localparam logic [2:0] S_DONE     = 3'd6;

    logic [2:0]        r_state;
    logic [BX_W-1:0]   r_bx;
    logic [BY_W-1:0]   r_by;
    logic [WX_W-1:0]   r_wx;
    logic [WY_W-1:0]   r_wy;
    // r_win_base = wy*FRM_BX + wx ; r_row_base = r_win_base + by*FRM_BX
    logic [ADDR_W-1:0] r_win_base;
    logic [ADDR_W-1:0] r_row_base;
    logic [SW_W-1:0]   r_sw_id;
    logic [DATA_W-1:0] r_svm_data;
    logic              r_det_valid;
    logic [SW_W-1:0]   r_det_sw_id;
    logic              r_det_is_person;
    logic [FEA_W-1:0]  r_det_score;
    logic [SW_W-1:0]   r_person_cnt;

    logic              w_timeout;
    logic              w_res_fire;
    logic              w_res_person;
    logic [FEA_W-1:0]  w_res_score;
    logic              w_last_bx;
    logic              w_last_by;
    logic              w_last_wx;
    logic              w_last_win;

    assign w_last_bx  = (r_bx == BX_W'(WIN_BX - 1));
    assign w_last_by  = (r_by == BY_W'(WIN_BY - 1));
    assign w_last_wx  = (r_wx == WX_W'(NWX - 1));
    assign w_last_win = w_last_wx && (r_wy == WY_W'(NWY - 1));

    // A real result always wins over a timeout arriving in the same cycle.
    assign w_res_fire   = (r_state == S_WAIT_RES) && (svm_o_valid || w_timeout);
    assign w_res_person = svm_o_valid ? svm_is_person : 1'b0;
    assign w_res_score  = svm_o_valid ? svm_result : '0;

`ifdef SCHED_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0] r_to_cnt;
    logic            r_err_timeout;

    assign w_timeout   = (r_state == S_WAIT_RES) && !svm_o_valid &&
                         (r_to_cnt == TO_W'(TIMEOUT));
    assign err_timeout = r_err_timeout;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_to_cnt      <= '0;
            r_err_timeout <= 1'b0;
        end else begin
            if ((r_state == S_WAIT_RES) && !w_res_fire)
                r_to_cnt <= r_to_cnt + TO_W'(1);
            else
                r_to_cnt <= '0;
            if ((r_state == S_IDLE) && start)
                r_err_timeout <= 1'b0;
            else if (w_timeout)
                r_err_timeout <= 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_bx            <= '0;
            r_by            <= '0;
            r_wx            <= '0;
            r_wy            <= '0;
            r_win_base      <= '0;
            r_row_base      <= '0;
            r_sw_id         <= '0;
            r_svm_data      <= '0;
            r_det_valid     <= 1'b0;
            r_det_sw_id     <= '0;
            r_det_is_person <= 1'b0;
            r_det_score     <= '0;
            r_person_cnt    <= '0;
        end else begin
            r_det_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state      <= S_WAIT_REQ;
                        r_bx         <= '0;
                        r_by         <= '0;
                        r_wx         <= '0;
                        r_wy         <= '0;
                        r_win_base   <= '0;
                        r_row_base   <= '0;
                        r_sw_id      <= '0;
                        r_person_cnt <= '0;
                    end
                end
                S_WAIT_REQ: if (svm_request) r_state <= S_READ;
                S_READ:     r_state <= S_LOAD;
                S_LOAD: begin
                    r_svm_data <= rd_data;
                    r_state    <= S_PRESENT;
                end
                S_PRESENT: begin
                    if (w_last_bx) begin
                        r_bx <= '0;
                        if (w_last_by) begin
                            r_by    <= '0;
                            r_state <= S_WAIT_RES;
                        end else begin
                            r_by       <= r_by + BY_W'(1);
                            r_row_base <= r_row_base + ADDR_W'(FRM_BX);
                            r_state    <= S_WAIT_REQ;
                        end
                    end else begin
                        r_bx    <= r_bx + BX_W'(1);
                        r_state <= S_WAIT_REQ;
                    end
                end
                S_WAIT_RES: begin
                    if (w_res_fire) begin
                        r_det_valid     <= 1'b1;
                        r_det_sw_id     <= r_sw_id;
                        r_det_is_person <= w_res_person;
                        r_det_score     <= w_res_score;
                        if (w_res_person && (r_person_cnt != '1))
                            r_person_cnt <= r_person_cnt + SW_W'(1);
                        if (w_last_win) begin
                            r_state <= S_DONE;
                        end else begin
                            r_sw_id <= r_sw_id + SW_W'(1);
                            r_state <= S_WAIT_REQ;
                            if (w_last_wx) begin
                                // Row wrap: from wy*FRM_BX+NWX-1 to (wy+1)*FRM_BX
                                // is exactly +WIN_BX.
                                r_wx       <= '0;
                                r_wy       <= r_wy + WY_W'(1);
                                r_win_base <= r_win_base + ADDR_W'(WIN_BX);
                                r_row_base <= r_win_base + ADDR_W'(WIN_BX);
                            end else begin
                                r_wx       <= r_wx + WX_W'(1);
                                r_win_base <= r_win_base + ADDR_W'(1);
                                r_row_base <= r_win_base + ADDR_W'(1);
                            end
                        end
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy          = (r_state != S_IDLE) && (r_state != S_DONE);
    assign done          = (r_state == S_DONE);
    assign rd_en         = (r_state == S_READ);
    assign rd_addr       = r_row_base + ADDR_W'(r_bx);
    assign svm_ready     = (r_state == S_PRESENT);
    assign svm_data      = r_svm_data;
    assign det_valid     = r_det_valid;
    assign det_sw_id     = r_det_sw_id;
    assign det_is_person = r_det_is_person;
    assign det_score     = r_det_score;
    assign person_cnt    = r_person_cnt;

endmodule

// File: tb/tb_svm_window_scheduler.sv
// ---------------------------------------------------------------------------
// tb_svm_window_scheduler
//
// Small-frame bench (4x3 blocks, 2x2 window, 6 windows of 4 blocks). A
// per-window vector table holds the expected read addresses plus the SVM
// response and the expected person count. Hand-written sequences cover
// ignored inputs, reset mid-frame and, when built with SCHED_TIMEOUT_EN,
// a window whose result never arrives.
// ---------------------------------------------------------------------------
module tb_svm_window_scheduler;
    localparam int DW  = 32;
    localparam int AW  = 4;
    localparam int SWW = 11;
    localparam int FW  = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic           busy;
    logic           done;
    logic           rd_en;
    logic [AW-1:0]  rd_addr;
    logic [DW-1:0]  rd_data;
    logic           svm_request;
    logic           svm_ready;
    logic [DW-1:0]  svm_data;
    logic           svm_o_valid;
    logic           svm_is_person;
    logic [FW-1:0]  svm_result;
    logic           det_valid;
    logic [SWW-1:0] det_sw_id;
    logic           det_is_person;
    logic [FW-1:0]  det_score;
    logic [SWW-1:0] person_cnt;
`ifdef SCHED_TIMEOUT_EN
    logic           err_timeout;
`endif

    always #5 clk = ~clk;

    svm_window_scheduler #(
        .DATA_W(DW), .SW_W(SWW), .FRM_BX(4), .FRM_BY(3),
        .WIN_BX(2), .WIN_BY(2), .ADDR_W(AW), .FEA_W(FW)
`ifdef SCHED_TIMEOUT_EN
        , .TIMEOUT(20)
`endif
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .svm_request(svm_request), .svm_ready(svm_ready), .svm_data(svm_data),
        .svm_o_valid(svm_o_valid), .svm_is_person(svm_is_person),
        .svm_result(svm_result), .det_valid(det_valid), .det_sw_id(det_sw_id),
        .det_is_person(det_is_person), .det_score(det_score),
        .person_cnt(person_cnt)
`ifdef SCHED_TIMEOUT_EN
        , .err_timeout(err_timeout)
`endif
    );

    // Buffer model: each address holds a distinct recognisable word.
    function automatic logic [DW-1:0] word(input logic [AW-1:0] a);
        return 32'hD000_0000 + 32'(a) * 32'h0001_0101;
    endfunction

    always @(posedge clk) if (rd_en) rd_data <= word(rd_addr);

    typedef struct {
        logic [15:0]    addrs;    // four 4-bit addresses, first block in MSBs
        logic           is_p;
        logic [FW-1:0]  score;
        logic [SWW-1:0] exp_cnt;  // person_cnt after this window is reported
    } win_vec_t;

    win_vec_t tbl[6];
    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One request -> rd_en next cycle -> svm_ready three cycles after request.
    task automatic do_block(input logic [AW-1:0] a);
        @(negedge clk); svm_request = 1'b1;
        @(negedge clk); svm_request = 1'b0;
        chk("rd_en", rd_en, 1'b1);
        chk("rd_addr", rd_addr, a);
        @(negedge clk);
        chk("load_no_ready", {rd_en, svm_ready}, 2'b00);
        @(negedge clk);
        chk("svm_ready", svm_ready, 1'b1);
        chk("svm_data", svm_data, word(a));
        $display("block addr=%0d data=%h", a, svm_data);
    endtask

    task automatic do_result(input logic p, input logic [FW-1:0] s,
                             input int id, input logic [SWW-1:0] cnt, input bit last);
        @(negedge clk);
        svm_o_valid = 1'b1; svm_is_person = p; svm_result = s;
        @(negedge clk);
        svm_o_valid = 1'b0; svm_is_person = 1'b0; svm_result = '0;
        chk("det_valid", det_valid, 1'b1);
        chk("det_sw_id", det_sw_id, SWW'(id));
        chk("det_is_person", det_is_person, p);
        chk("det_score", det_score, s);
        chk("person_cnt", person_cnt, cnt);
        chk("done", done, last);
        $display("window id=%0d person=%0d score=%h cnt=%0d", det_sw_id,
                 det_is_person, det_score, person_cnt);
        if (last) begin
            @(negedge clk);
            chk("done_pulse_end", {done, busy, det_valid}, 3'b000);
        end
    endtask

    task automatic run_blocks(input int w, input int first);
        logic [15:0] av;
        av = tbl[w].addrs;
        for (int b = first; b < 4; b++) do_block(av[15-4*b -: 4]);
    endtask

    task automatic run_window(input int w, input int first);
        run_blocks(w, first);
        do_result(tbl[w].is_p, tbl[w].score, w, tbl[w].exp_cnt, w == 5);
    endtask

    task automatic start_frame();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("busy_after_start", busy, 1'b1);
    endtask

    task automatic chk_all_zero(input string nm);
        chk(nm, {busy, done, rd_en, rd_addr, svm_ready, det_valid, det_is_person}, '0);
        chk({nm, "_data"}, {svm_data, det_score}, '0);
        chk({nm, "_cnt"}, {det_sw_id, person_cnt}, '0);
    endtask

    initial begin
        tbl[0] = '{16'h0145, 1'b0, 32'h0000_1111, 11'd0};
        tbl[1] = '{16'h1256, 1'b0, 32'hFFFF_FF80, 11'd0};
        tbl[2] = '{16'h2367, 1'b1, 32'h0001_2345, 11'd1};
        tbl[3] = '{16'h4589, 1'b0, 32'h0000_0000, 11'd1};
        tbl[4] = '{16'h569A, 1'b1, 32'h7FFF_0001, 11'd2};
        tbl[5] = '{16'h67AB, 1'b0, 32'h8000_0000, 11'd2};

        rst = 1'b1; start = 1'b0; svm_request = 1'b0; svm_o_valid = 1'b0;
        svm_is_person = 1'b0; svm_result = '0; rd_data = '0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;

        // Frame 1: full table.
        start_frame();
        for (int w = 0; w < 6; w++) run_window(w, 0);

        // Frame 2: inject ignored inputs while PRESENT is on.
        start_frame();
        chk("cnt_cleared", person_cnt, 11'd0);
        do_block(4'd0);
        start = 1'b1; svm_o_valid = 1'b1; svm_request = 1'b1; svm_is_person = 1'b1;
        @(negedge clk);
        start = 1'b0; svm_o_valid = 1'b0; svm_request = 1'b0; svm_is_person = 1'b0;
        chk("ign_no_read", {rd_en, det_valid}, 2'b00);
        @(negedge clk);
        chk("ign_still_idle", {rd_en, det_valid, busy}, 3'b001);
        run_window(0, 1);
        run_window(1, 0);
        run_window(2, 0);

        // Reset mid-frame, then restart from window 0.
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk_all_zero("midreset");
        start_frame();
        run_window(0, 0);

`ifdef SCHED_TIMEOUT_EN
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        start_frame();
        chk("err_clear", err_timeout, 1'b0);
        run_window(0, 0);
        run_blocks(1, 0);
        begin
            int k;
            k = 0;
            while (!det_valid && k < 60) begin @(negedge clk); k++; end
            chk("timeout_seen", det_valid, 1'b1);
        end
        chk("to_sw_id", det_sw_id, 11'd1);
        chk("to_person_score", {det_is_person, det_score}, '0);
        chk("err_timeout", err_timeout, 1'b1);
        $display("window id=%0d timed out, err_timeout=%0d", det_sw_id, err_timeout);
        for (int w = 2; w < 6; w++) run_window(w, 0);
        chk("err_sticky", err_timeout, 1'b1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
